// File: rtl/oversample_pkg.sv
// rtl/oversample_pkg.sv - shared widths and helpers for the multi-channel oversampler
package oversample_pkg;

  localparam int DEF_CH_W = 4;

  function automatic int acc_w(input int sample_w, input int max_log2r);
    return sample_w + max_log2r;
  endfunction

  // Half the extra bits are kept: 2^r samples buy r/2 bits of resolution.
  function automatic int out_w(input int sample_w, input int max_log2r);
    return sample_w + max_log2r / 2;
  endfunction

  function automatic int entry_w(input int o_w, input int ch_w);
    return o_w + ch_w;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - same-clock first-word fall-through FIFO
module sync_fifo
  import oversample_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
  end

  assign rdata = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/oversample_multi.sv
// rtl/oversample_multi.sv - per-channel 2^r accumulate-and-decimate with output FIFO
module oversample_multi
  import oversample_pkg::*;
#(
  parameter int SAMPLE_W   = 12,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = DEF_CH_W,
  parameter int MAX_LOG2R  = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int ACC_W     = acc_w(SAMPLE_W, MAX_LOG2R),
  localparam int OUT_W     = out_w(SAMPLE_W, MAX_LOG2R)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [CH_W-1:0]     sample_ch,
  input  logic                eoc,
  input  logic [3:0]          ratio_log2,
  input  logic [NUM_CH-1:0]   ch_enable,
  output logic [OUT_W-1:0]    out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic                bad_ch
);

  localparam int ENT_W = entry_w(OUT_W, CH_W);
  localparam int CNT_W = MAX_LOG2R;

  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [ACC_W-1:0] acc_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [3:0]       r_q, r_eff, shamt;
  logic             r_change, ch_oob;
  logic [CNT_W:0]   one_hot;
  logic [CNT_W-1:0] last_cnt;
  logic [ACC_W-1:0] sum, scaled;
  logic             push_q, push_d;
  logic [ENT_W-1:0] ent_q, ent_d, last_q;
  logic             overflow_q, bad_ch_q;
  logic [ENT_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;

  always_comb begin
    r_eff    = (ratio_log2 > 4'(MAX_LOG2R)) ? 4'(MAX_LOG2R) : ratio_log2;
    r_change = (r_eff != r_q);
    ch_oob   = eoc && (32'(sample_ch) >= NUM_CH);
    one_hot  = (CNT_W+1)'(1) << r_q;
    last_cnt = CNT_W'(one_hot - 1'b1);
    shamt    = 4'(MAX_LOG2R) - r_q;
    sum      = '0;
    scaled   = '0;
    push_d   = 1'b0;
    ent_d    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c] = acc_q[c];
      cnt_d[c] = cnt_q[c];
      if (r_change || !ch_enable[c]) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
      end else if (eoc && sample_ch == CH_W'(c)) begin
        sum = acc_q[c] + ACC_W'(sample);
        if (cnt_q[c] == last_cnt) begin
          // MSB-align so every ratio lands on the same output scale.
          scaled   = sum << shamt;
          push_d   = 1'b1;
          ent_d    = {scaled[ACC_W-1 -: OUT_W], CH_W'(c)};
          acc_d[c] = '0;
          cnt_d[c] = '0;
        end else begin
          acc_d[c] = sum;
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  assign fifo_pop = out_ready && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      r_q        <= r_eff;
      push_q     <= 1'b0;
      ent_q      <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
      bad_ch_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      r_q    <= r_eff;
      push_q <= push_d;
      ent_q  <= ent_d;
      if (ch_oob) bad_ch_q <= 1'b1;
      if (push_q && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      if (fifo_pop) last_q <= fifo_rdata;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_q),
    .wdata   (ent_q),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Holding the last popped word keeps out_data steady while the FIFO is empty.
  assign {out_data, out_ch} = fifo_empty ? last_q : fifo_rdata;
  assign out_valid          = !fifo_empty;
  assign overflow           = overflow_q;
  assign bad_ch             = bad_ch_q;

endmodule

// File: tb/tb_oversample_multi.sv
// tb/tb_oversample_multi.sv - directed-vector bench for oversample_multi
module tb_oversample_multi;

  logic        clk;
  logic        reset_n;
  logic [11:0] sample;
  logic [3:0]  sample_ch;
  logic        eoc;
  logic [3:0]  ratio_log2;
  logic [3:0]  ch_enable;
  logic [15:0] out_data;
  logic [3:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        bad_ch;

  int vectors;
  int miscompares;

  oversample_multi dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample     (sample),
    .sample_ch  (sample_ch),
    .eoc        (eoc),
    .ratio_log2 (ratio_log2),
    .ch_enable  (ch_enable),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .bad_ch     (bad_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] ch, input logic [11:0] s);
    sample    = s;
    sample_ch = ch;
    eoc       = 1'b1;
    tick();
    eoc       = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] d, input logic [3:0] ch);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"}, 32'(out_data), 32'(d));
    chk({tag, " ch"}, 32'(out_ch), 32'(ch));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    sample      = '0;
    sample_ch   = '0;
    eoc         = 1'b0;
    ratio_log2  = 4'd4;
    ch_enable   = 4'hF;
    out_ready   = 1'b0;
    repeat (3) tick();
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst data", 32'(out_data), 32'd0);
    chk("rst ch", 32'(out_ch), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst bad_ch", 32'(bad_ch), 32'd0);
    reset_n = 1'b1;
    tick();

    // r=4: 16 x FFF sums to FFF0, shifted by 4 and topped to 16 bits -> FFF0
    for (int i = 0; i < 15; i++) send(4'd0, 12'hFFF);
    chk("r4 partial", 32'(out_valid), 32'd0);
    send(4'd0, 12'hFFF);
    chk("r4 latency E", 32'(out_valid), 32'd0);
    tick();
    pop_expect("r4", 16'hFFF0, 4'd0);
    chk("r4 empty", 32'(out_valid), 32'd0);
    chk("r4 hold", 32'(out_data), 32'hFFF0);

    // r=8: 256 x 800 = 80000 -> 8000
    ratio_log2 = 4'd8;
    tick();
    for (int i = 0; i < 256; i++) send(4'd0, 12'h800);
    tick();
    pop_expect("r8", 16'h8000, 4'd0);

    // r=0 pass-through: 001 << 8 = 00100 -> 0010
    ratio_log2 = 4'd0;
    tick();
    send(4'd0, 12'h001);
    tick();
    pop_expect("r0", 16'h0010, 4'd0);

    // r=2 interleaved: ch0 4x100=400<<6 -> 1000, ch1 4x200=800<<6 -> 2000
    ratio_log2 = 4'd2;
    tick();
    for (int i = 0; i < 8; i++) send(4'(i % 2), (i % 2) ? 12'h200 : 12'h100);
    tick();
    pop_expect("il ch0", 16'h1000, 4'd0);
    pop_expect("il ch1", 16'h2000, 4'd1);
    chk("il empty", 32'(out_valid), 32'd0);

    // Backpressure at r=0: sample k -> k<<4
    ratio_log2 = 4'd0;
    tick();
    for (int k = 1; k <= 9; k++) send(4'd0, 12'(k));
    chk("bp ovf before", 32'(overflow), 32'd0);
    send(4'd0, 12'd10);
    chk("bp ovf 9th", 32'(overflow), 32'd1);
    tick();
    chk("bp head", 32'(out_data), 32'h0010);
    send(4'd0, 12'd11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int k = 2; k <= 8; k++) pop_expect($sformatf("bp %0d", k), 16'(k * 16), 4'd0);
    pop_expect("bp full+pop", 16'h00B0, 4'd0);
    chk("bp empty", 32'(out_valid), 32'd0);

    // Ratio change mid-window: r=4 partial discarded, r=2 fires after 4 eoc
    ratio_log2 = 4'd4;
    tick();
    for (int i = 0; i < 10; i++) send(4'd0, 12'h001);
    ratio_log2 = 4'd2;
    tick();
    for (int i = 0; i < 3; i++) send(4'd0, 12'h002);
    tick();
    chk("rc partial", 32'(out_valid), 32'd0);
    send(4'd0, 12'h002);
    tick();
    pop_expect("rc", 16'h0020, 4'd0);

    // Out-of-range tag
    send(4'd4, 12'hFFF);
    tick();
    chk("badch flag", 32'(bad_ch), 32'd1);
    chk("badch nopush", 32'(out_valid), 32'd0);

    // Disabling ch0 mid-window restarts its count
    send(4'd0, 12'h100);
    send(4'd0, 12'h100);
    ch_enable = 4'hE;
    tick();
    ch_enable = 4'hF;
    tick();
    for (int i = 0; i < 3; i++) send(4'd0, 12'h100);
    tick();
    chk("en cleared", 32'(out_valid), 32'd0);
    send(4'd0, 12'h100);
    tick();
    chk("en out", 32'(out_data), 32'h1000);

    // Reset with three entries queued
    ratio_log2 = 4'd0;
    tick();
    send(4'd0, 12'h005);
    send(4'd1, 12'h006);
    tick();
    chk("pre-rst valid", 32'(out_valid), 32'd1);
    chk("pre-rst ovf", 32'(overflow), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("mr valid", 32'(out_valid), 32'd0);
    chk("mr data", 32'(out_data), 32'd0);
    chk("mr ovf", 32'(overflow), 32'd0);
    chk("mr bad_ch", 32'(bad_ch), 32'd0);
    reset_n = 1'b1;
    tick();
    send(4'd2, 12'h003);
    tick();
    pop_expect("post-rst", 16'h0030, 4'd2);
    chk("post-rst empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
